lstm_wb_loader: RTL and testbench

Controller that initializes the LSTM weight BRAM (256×2048) and bias BRAM (16×512) from a streaming source and then time-shares both BRAM ports with the LSTM compute FSM's read requests. It sits between the top-level loader interface, the two BRAM instances, and the LSTM core. It owns every BRAM control signal, so the core never drives the BRAMs directly.

---
 rtl/lstm_pkg.sv | 22 ++
 rtl/lstm_rd_pipe.sv | 43 ++++
 rtl/lstm_wb_loader.sv | 166 ++++++++++++++++
 tb/tb_lstm_wb_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Purpose: shared types and constants for the LSTM weight/bias loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lstm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        LOAD_B = 2'd2,
        DONE   = 2'd3
    } ld_state_t;

    localparam logic TGT_W = 1'b0;
    localparam logic TGT_B = 1'b1;

    localparam int W_DEPTH = 2048;
    localparam int B_DEPTH = 512;

    localparam int W_DW = 256;   // weight word width
    localparam int B_DW = 16;    // bias word width

endpackage

// File: rtl/lstm_rd_pipe.sv
// Purpose: aligns read-valid with BRAM output and captures the read word.
// Latency: grant at cycle t -> rd_valid and data during cycle t+2.
// Backpressure: none; one read per cycle, data holds between reads.
// Ports: gnt/sel from the arbiter, w_dout/b_dout from the BRAMs,
//        rd_valid/wdata/bdata towards the LSTM core.
module lstm_rd_pipe
    import lstm_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            gnt,
    input  logic            sel,
    input  logic [W_DW-1:0] w_dout,
    input  logic [B_DW-1:0] b_dout,
    output logic            rd_valid,
    output logic [W_DW-1:0] wdata,
    output logic [B_DW-1:0] bdata
);

    // Stage 1 tracks the cycle the BRAM sees its enable; stage 2 is the
    // cycle the captured word is presented.
    logic v1;
    logic s1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1       <= 1'b0;
            s1       <= TGT_W;
            rd_valid <= 1'b0;
            wdata    <= '0;
            bdata    <= '0;
        end else begin
            v1       <= gnt;
            s1       <= sel;
            rd_valid <= v1;
            // Only the selected port's register is refreshed so the other
            // side keeps its last read word.
            if (v1 && s1 == TGT_W) wdata <= w_dout;
            if (v1 && s1 == TGT_B) bdata <= b_dout;
        end
    end

endmodule

// File: rtl/lstm_wb_loader.sv
// Purpose: loads weight/bias BRAMs from a stream, then arbitrates core reads onto them.
// Latency: N-beat load start->oLoad_done = N+2 cycles; read grant->oRd_valid = 2 cycles.
// Backpressure: oWb_ready high only while loading; reads are held off (not granted) during a load.
// Ports: iLoad_* load request, iWb_*/oWb_ready stream, oLoad_done/oLoad_err/oInit_done status,
//        iRd_*/oRd_* core read port, oW_*/oB_* BRAM controls, iW_dout/iB_dout BRAM data.
module lstm_wb_loader
    import lstm_pkg::*;
#(
    parameter int W_AW = $clog2(W_DEPTH),
    parameter int B_AW = $clog2(B_DEPTH)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            iLoad_start,
    input  logic            iLoad_target,
    input  logic [W_AW-1:0] iLoad_base,
    input  logic [W_AW:0]   iLoad_count,
    input  logic            iWb_valid,
    output logic            oWb_ready,
    input  logic [W_DW-1:0] iWb_data,
    output logic            oLoad_done,
    output logic            oLoad_err,
    output logic            oInit_done,
    input  logic            iRd_req,
    input  logic            iRd_sel,
    input  logic [W_AW-1:0] iRd_addr,
    output logic            oRd_gnt,
    output logic            oRd_valid,
    output logic [W_DW-1:0] oRd_wdata,
    output logic [B_DW-1:0] oRd_bdata,
    output logic            oW_en,
    output logic            oW_we,
    output logic [W_AW-1:0] oW_addr,
    output logic [W_DW-1:0] oW_din,
    output logic            oB_en,
    output logic            oB_we,
    output logic [B_AW-1:0] oB_addr,
    output logic [B_DW-1:0] oB_din,
    input  logic [W_DW-1:0] iW_dout,
    input  logic [B_DW-1:0] iB_dout
);

    localparam int SW = W_AW + 2;   // wide enough for base + count without overflow

    ld_state_t       state;
    logic            tgt_r;
    logic [W_AW-1:0] addr_cnt;
    logic [W_AW:0]   beat_cnt;
    logic [W_AW:0]   last_beat;
    logic            w_loaded;
    logic            b_loaded;
    logic            rd_gnt;

    logic [SW-1:0]   load_end;
    logic [SW-1:0]   load_lim;
    logic            load_oob;

    // Range check uses the full base even for bias, so an out-of-range
    // bias base is rejected rather than silently truncated.
    assign load_end = SW'(iLoad_base) + SW'(iLoad_count);
    assign load_lim = (iLoad_target == TGT_B) ? SW'(2 ** B_AW) : SW'(2 ** W_AW);
    assign load_oob = load_end > load_lim;

    // A start in the same cycle as a request takes priority over the read.
    assign rd_gnt     = resetn && (state == IDLE) && iRd_req && !iLoad_start;
    assign oRd_gnt    = rd_gnt;
    assign oWb_ready  = (state == LOAD_W) || (state == LOAD_B);
    assign oInit_done = w_loaded && b_loaded;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            tgt_r      <= TGT_W;
            addr_cnt   <= '0;
            beat_cnt   <= '0;
            last_beat  <= '0;
            w_loaded   <= 1'b0;
            b_loaded   <= 1'b0;
            oLoad_done <= 1'b0;
            oLoad_err  <= 1'b0;
            oW_en      <= 1'b0;
            oW_we      <= 1'b0;
            oW_addr    <= '0;
            oW_din     <= '0;
            oB_en      <= 1'b0;
            oB_we      <= 1'b0;
            oB_addr    <= '0;
            oB_din     <= '0;
        end else begin
            // Strobes default low; addr/din registers hold between accesses.
            oLoad_done <= 1'b0;
            oLoad_err  <= 1'b0;
            oW_en      <= 1'b0;
            oW_we      <= 1'b0;
            oB_en      <= 1'b0;
            oB_we      <= 1'b0;
            case (state)
                IDLE: begin
                    if (iLoad_start) begin
                        if (load_oob) begin
                            oLoad_err <= 1'b1;
                        end else begin
                            tgt_r     <= iLoad_target;
                            addr_cnt  <= iLoad_base;
                            beat_cnt  <= '0;
                            last_beat <= iLoad_count - 1'b1;
                            if (iLoad_count == '0)
                                state <= DONE;
                            else if (iLoad_target == TGT_B)
                                state <= LOAD_B;
                            else
                                state <= LOAD_W;
                        end
                    end else if (rd_gnt) begin
                        if (iRd_sel == TGT_B) begin
                            oB_en   <= 1'b1;
                            oB_addr <= iRd_addr[B_AW-1:0];
                        end else begin
                            oW_en   <= 1'b1;
                            oW_addr <= iRd_addr;
                        end
                    end
                end
                LOAD_W, LOAD_B: begin
                    // oWb_ready is high in these states, so valid alone accepts.
                    if (iWb_valid) begin
                        if (state == LOAD_B) begin
                            oB_en   <= 1'b1;
                            oB_we   <= 1'b1;
                            oB_addr <= addr_cnt[B_AW-1:0];
                            oB_din  <= iWb_data[B_DW-1:0];
                        end else begin
                            oW_en   <= 1'b1;
                            oW_we   <= 1'b1;
                            oW_addr <= addr_cnt;
                            oW_din  <= iWb_data;
                        end
                        addr_cnt <= addr_cnt + 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == last_beat) state <= DONE;
                    end
                end
                DONE: begin
                    oLoad_done <= 1'b1;
                    if (tgt_r == TGT_B) b_loaded <= 1'b1;
                    else                w_loaded <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    lstm_rd_pipe u_rd_pipe (
        .clk      (clk),
        .resetn   (resetn),
        .gnt      (rd_gnt),
        .sel      (iRd_sel),
        .w_dout   (iW_dout),
        .b_dout   (iB_dout),
        .rd_valid (oRd_valid),
        .wdata    (oRd_wdata),
        .bdata    (oRd_bdata)
    );

endmodule

// File: tb/tb_lstm_wb_loader.sv
// Purpose: self-checking bench for lstm_wb_loader with BRAM stand-ins and a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_lstm_wb_loader;
    import lstm_pkg::*;

    logic         clk;
    logic         resetn;
    logic         iLoad_start;
    logic         iLoad_target;
    logic [10:0]  iLoad_base;
    logic [11:0]  iLoad_count;
    logic         iWb_valid;
    logic         oWb_ready;
    logic [255:0] iWb_data;
    logic         oLoad_done;
    logic         oLoad_err;
    logic         oInit_done;
    logic         iRd_req;
    logic         iRd_sel;
    logic [10:0]  iRd_addr;
    logic         oRd_gnt;
    logic         oRd_valid;
    logic [255:0] oRd_wdata;
    logic [15:0]  oRd_bdata;
    logic         oW_en, oW_we;
    logic [10:0]  oW_addr;
    logic [255:0] oW_din;
    logic         oB_en, oB_we;
    logic [8:0]   oB_addr;
    logic [15:0]  oB_din;
    logic [255:0] iW_dout;
    logic [15:0]  iB_dout;

    lstm_wb_loader dut (
        .clk(clk), .resetn(resetn),
        .iLoad_start(iLoad_start), .iLoad_target(iLoad_target),
        .iLoad_base(iLoad_base), .iLoad_count(iLoad_count),
        .iWb_valid(iWb_valid), .oWb_ready(oWb_ready), .iWb_data(iWb_data),
        .oLoad_done(oLoad_done), .oLoad_err(oLoad_err), .oInit_done(oInit_done),
        .iRd_req(iRd_req), .iRd_sel(iRd_sel), .iRd_addr(iRd_addr),
        .oRd_gnt(oRd_gnt), .oRd_valid(oRd_valid),
        .oRd_wdata(oRd_wdata), .oRd_bdata(oRd_bdata),
        .oW_en(oW_en), .oW_we(oW_we), .oW_addr(oW_addr), .oW_din(oW_din),
        .oB_en(oB_en), .oB_we(oB_we), .oB_addr(oB_addr), .oB_din(oB_din),
        .iW_dout(iW_dout), .iB_dout(iB_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM stand-ins: synchronous write, data presented the cycle after the
    // registered read enable.
    logic [255:0] w_ram [0:2047];
    logic [15:0]  b_ram [0:511];
    always @(posedge clk) begin
        if (oW_en && oW_we) w_ram[oW_addr] <= oW_din;
        if (oB_en && oB_we) b_ram[oB_addr] <= oB_din;
    end
    assign iW_dout = (oW_en && !oW_we) ? w_ram[oW_addr] : {8{32'hDEADBEEF}};
    assign iB_dout = (oB_en && !oB_we) ? b_ram[oB_addr] : 16'hBEEF;

    typedef struct { int addr; logic [255:0] data; } wr_t;

    int checks = 0;
    int passes = 0;
    int hold_bad = 0;
    wr_t wq[$];
    wr_t bq[$];
    logic [255:0] ref_w [int];
    logic [15:0]  ref_b [int];
    int w_addrs[$];
    int b_addrs[$];
    logic [255:0] last_w = '0;
    logic [15:0]  last_b = '0;
    logic [10:0]  pw_addr = '0;
    logic [255:0] pw_din = '0;
    logic [8:0]   pb_addr = '0;
    logic [15:0]  pb_din = '0;
    bit  rd_sel_q[$];
    int  rd_addr_q[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    // Advance to the middle of the next cycle and log BRAM activity.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (oW_en && oW_we) wq.push_back('{int'(oW_addr), oW_din});
        if (oB_en && oB_we) bq.push_back('{int'(oB_addr), 256'(oB_din)});
        if (resetn && !oW_en && (oW_addr !== pw_addr || oW_din !== pw_din)) hold_bad++;
        if (resetn && !oB_en && (oB_addr !== pb_addr || oB_din !== pb_din)) hold_bad++;
        pw_addr = oW_addr; pw_din = oW_din;
        pb_addr = oB_addr; pb_din = oB_din;
    endtask

    // mode: 0 continuous valid, 1 valid on odd cycles (1,0,1,0...), 2 random valid.
    task automatic do_load(input bit tgt, input int base, input int cnt, input int mode,
                           input bit hold_req, input string tag);
        wr_t exp_q[$];
        wr_t cap[$];
        wr_t other[$];
        int sent, lat, gnt_cyc, early_gnt, dones, errs, a;
        bit rej;
        logic [255:0] d;
        rej = (base + cnt) > (tgt == TGT_B ? B_DEPTH : W_DEPTH);
        sent = 0; lat = -1; gnt_cyc = -1; early_gnt = 0; dones = 0; errs = 0;
        wq.delete(); bq.delete();
        iLoad_start = 1'b1; iLoad_target = tgt;
        iLoad_base = 11'(base); iLoad_count = 12'(cnt); iWb_valid = 1'b0;
        iRd_req = hold_req; iRd_sel = TGT_W; iRd_addr = 11'd0;
        #1;
        if (hold_req) chk({tag, " gnt_with_start"}, oRd_gnt, 0);
        for (int c = 1; c <= 6 * cnt + 12; c++) begin
            tick();
            iLoad_start = 1'b0;
            if (gnt_cyc >= 0) iRd_req = 1'b0;
            #1;
            if (oLoad_err) errs++;
            if (oLoad_done) begin dones++; if (lat < 0) lat = c; end
            if (hold_req && iRd_req && oRd_gnt) begin
                if (lat < 0) early_gnt++;
                gnt_cyc = c;
            end
            iWb_valid = 1'b0;
            if (sent < cnt && (mode == 0 || (mode == 1 && c % 2 == 1) ||
                               (mode == 2 && $urandom_range(0, 1) == 1))) begin
                d = rnd256();
                iWb_valid = 1'b1; iWb_data = d;
                if (oWb_ready) begin
                    if (tgt == TGT_B) begin
                        a = (base + sent) % B_DEPTH;
                        exp_q.push_back('{a, 256'(d[15:0])});
                        ref_b[a] = d[15:0]; b_addrs.push_back(a);
                    end else begin
                        a = base + sent;
                        exp_q.push_back('{a, d});
                        ref_w[a] = d; w_addrs.push_back(a);
                    end
                    sent++;
                end
            end
        end
        iWb_valid = 1'b0; iRd_req = 1'b0;
        if (gnt_cyc >= 0) last_w = ref_w[0];
        chk({tag, " err_pulses"}, errs, rej ? 1 : 0);
        chk({tag, " done_pulses"}, dones, rej ? 0 : 1);
        chk({tag, " beats_taken"}, sent, rej ? 0 : cnt);
        if (!rej && mode == 0) chk({tag, " latency"}, lat, cnt == 0 ? 2 : cnt + 2);
        cap = (tgt == TGT_B) ? bq : wq;
        other = (tgt == TGT_B) ? wq : bq;
        chk({tag, " n_writes"}, cap.size(), exp_q.size());
        chk({tag, " other_bram_writes"}, other.size(), 0);
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            chk($sformatf("%s wr%0d_addr", tag, i), cap[i].addr, exp_q[i].addr);
            chk($sformatf("%s wr%0d_data", tag, i), cap[i].data, exp_q[i].data);
        end
        if (hold_req) begin
            chk({tag, " early_gnt"}, early_gnt, 0);
            chk({tag, " gnt_after_done"}, (lat > 0 && gnt_cyc >= lat && gnt_cyc <= lat + 1), 1);
        end
    endtask

    // Issue the queued reads on consecutive cycles and check the returned words.
    task automatic do_reads(input string tag);
        int n;
        n = rd_addr_q.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                iRd_req = 1'b1; iRd_sel = rd_sel_q[i]; iRd_addr = 11'(rd_addr_q[i]);
                #1;
                chk($sformatf("%s gnt%0d", tag, i), oRd_gnt, 1);
            end else begin
                iRd_req = 1'b0;
            end
            tick();
            if (i == 0) begin
                chk({tag, " valid_t1"}, oRd_valid, 0);
            end else begin
                if (rd_sel_q[i-1] == TGT_B) last_b = ref_b[rd_addr_q[i-1] % B_DEPTH];
                else                        last_w = ref_w[rd_addr_q[i-1]];
                chk($sformatf("%s valid%0d", tag, i - 1), oRd_valid, 1);
                chk($sformatf("%s wdata%0d", tag, i - 1), oRd_wdata, last_w);
                chk($sformatf("%s bdata%0d", tag, i - 1), oRd_bdata, last_b);
            end
        end
        iRd_req = 1'b0;
        tick();
        chk({tag, " valid_end"}, oRd_valid, 0);
        rd_sel_q.delete(); rd_addr_q.delete();
    endtask

    initial begin
        logic [255:0] d;
        int n;
        bit tg;
        resetn = 1'b0; iLoad_start = 1'b0; iLoad_target = TGT_W; iLoad_base = '0;
        iLoad_count = '0; iWb_valid = 1'b0; iWb_data = '0;
        iRd_req = 1'b0; iRd_sel = TGT_W; iRd_addr = '0;
        repeat (3) tick();
        chk("rst_ctl", {oW_en, oW_we, oW_addr, oB_en, oB_we, oB_addr, oB_din, oWb_ready,
                        oRd_gnt, oRd_valid, oLoad_done, oLoad_err, oInit_done, oRd_bdata}, '0);
        chk("rst_w_din", oW_din, '0);
        chk("rst_rd_wdata", oRd_wdata, '0);
        resetn = 1'b1;
        repeat (2) tick();

        do_load(TGT_W, 0, 4, 0, 0, "w_base0");
        chk("init_after_w", oInit_done, 0);
        do_load(TGT_B, 510, 2, 0, 0, "b_510");
        chk("init_after_both", oInit_done, 1);
        do_load(TGT_B, 511, 2, 0, 0, "b_reject");

        rd_sel_q.push_back(TGT_W); rd_addr_q.push_back(3);
        do_reads("rd_w3");
        rd_sel_q.push_back(TGT_B); rd_addr_q.push_back(510);
        do_reads("rd_b510");

        do_load(TGT_W, 100, 3, 1, 0, "w_gappy");
        do_load(TGT_W, 200, 4, 0, 1, "w_vs_read");
        do_load(TGT_B, 5, 0, 0, 0, "b_zero");
        do_load(TGT_W, 2044, 4, 0, 0, "w_top_fit");
        do_load(TGT_W, 2045, 4, 0, 0, "w_top_over");

        for (int k = 0; k < 6; k++) begin
            tg = 1'($urandom_range(0, 1));
            do_load(tg, tg ? $urandom_range(500, 511) : $urandom_range(2038, 2047),
                    $urandom_range(0, 8), 2, 0, $sformatf("rnd%0d", k));
        end

        for (int k = 0; k < 8; k++) begin
            tg = 1'($urandom_range(0, 1));
            rd_sel_q.push_back(tg);
            if (tg) rd_addr_q.push_back(b_addrs[$urandom_range(0, b_addrs.size() - 1)]);
            else    rd_addr_q.push_back(w_addrs[$urandom_range(0, w_addrs.size() - 1)]);
        end
        do_reads("rd_burst");
        chk("init_sticky", oInit_done, 1);

        // Reset in the middle of a 4-beat load, after two beats are written.
        wq.delete();
        iLoad_start = 1'b1; iLoad_target = TGT_W; iLoad_base = 11'd8; iLoad_count = 12'd4;
        for (int c = 1; c <= 2; c++) begin
            tick();
            iLoad_start = 1'b0;
            d = rnd256();
            iWb_valid = 1'b1; iWb_data = d; ref_w[8 + c - 1] = d;
        end
        tick();
        iWb_valid = 1'b0;
        chk("mrst_pre_writes", wq.size(), 2);
        resetn = 1'b0;
        #1;
        chk("mrst_ctl", {oW_en, oW_we, oW_addr, oB_en, oB_we, oB_addr, oB_din, oWb_ready,
                         oRd_gnt, oRd_valid, oLoad_done, oLoad_err, oInit_done, oRd_bdata}, '0);
        chk("mrst_w_din", oW_din, '0);
        chk("mrst_rd_wdata", oRd_wdata, '0);
        last_w = '0; last_b = '0;
        n = 0;
        repeat (2) begin tick(); if (oLoad_done) n++; end
        resetn = 1'b1;
        repeat (8) begin tick(); if (oLoad_done) n++; end
        chk("mrst_no_done", n, 0);
        chk("mrst_init", oInit_done, 0);
        do_load(TGT_W, 16, 4, 0, 0, "post_rst");
        chk("post_rst_init", oInit_done, 0);

        chk("addr_din_hold", hold_bad, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
